// File: rtl/cgol_board.sv
// cgol_board: double-buffered Game of Life board (rule B3/S23).
// Seeds are written row by row into the active bank. A step request builds the
// next generation one row per cycle into the shadow bank, then the banks swap.
// Ports:
//   ph2       - clock, rising edge
//   reset     - asynchronous, active-high
//   we/wa/wd  - seed row write into the active bank (IDLE only)
//   step      - request one generation (IDLE only)
//   ra/rd     - combinational read of an active-bank row
//   busy      - high while a generation is in flight (COMPUTE and SWAP)
//   done      - one-cycle pulse after a generation is committed
//   gen_count - generations committed since reset, wraps at 2^16
//   alive     - OR of every cell in the active bank
module cgol_board #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned REGBITS = 3,
  parameter int unsigned WRAP    = 0
) (
  input  logic               ph2,
  input  logic               reset,
  input  logic               we,
  input  logic [REGBITS-1:0] wa,
  input  logic [WIDTH-1:0]   wd,
  input  logic               step,
  input  logic [REGBITS-1:0] ra,
  output logic [WIDTH-1:0]   rd,
  output logic               busy,
  output logic               done,
  output logic [15:0]        gen_count,
  output logic               alive
);

  localparam int unsigned ROWS = 2 ** REGBITS;
  localparam logic [REGBITS-1:0] LAST_ROW = REGBITS'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, COMPUTE, SWAP} state_t;

  state_t             state_q, state_d;
  logic [REGBITS-1:0] row_q;
  logic               sel_q;
  logic [WIDTH-1:0]   bank_q [2][ROWS];
  logic [WIDTH-1:0]   active [ROWS];
  logic [WIDTH-1:0]   up_row, dn_row, next_row;
  logic               seed_wr, row_wr, swap;

  // Column neighbours: bit i of the result holds column i-1 (west) or i+1 (east).
  function automatic logic [WIDTH-1:0] from_west(input logic [WIDTH-1:0] r);
    return {r[WIDTH-2:0], (WRAP != 0) ? r[WIDTH-1] : 1'b0};
  endfunction

  function automatic logic [WIDTH-1:0] from_east(input logic [WIDTH-1:0] r);
    return {(WRAP != 0) ? r[0] : 1'b0, r[WIDTH-1:1]};
  endfunction

  // Apply B3/S23 to one row given the rows above and below.
  function automatic logic [WIDTH-1:0] life_row(input logic [WIDTH-1:0] up,
                                                input logic [WIDTH-1:0] cur,
                                                input logic [WIDTH-1:0] dn);
    logic [WIDTH-1:0] uw, ue, cw, ce, dw, de, res;
    logic [3:0]       n;
    uw  = from_west(up);
    ue  = from_east(up);
    cw  = from_west(cur);
    ce  = from_east(cur);
    dw  = from_west(dn);
    de  = from_east(dn);
    res = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      n = 4'(uw[i]) + 4'(up[i]) + 4'(ue[i]) + 4'(cw[i]) +
          4'(ce[i]) + 4'(dw[i]) + 4'(dn[i]) + 4'(de[i]);
      res[i] = (n == 4'd3) | (cur[i] & (n == 4'd2));
    end
    return res;
  endfunction

  // Active bank view used for reads and as the source generation.
  always_comb begin
    for (int r = 0; r < int'(ROWS); r++) active[r] = bank_q[sel_q][r];
  end

  assign rd = active[ra];

  always_comb begin
    alive = 1'b0;
    for (int r = 0; r < int'(ROWS); r++) alive = alive | (|active[r]);
  end

  // Vertical neighbours; the row counter wraps naturally, the dead border masks it.
  always_comb begin
    up_row = active[REGBITS'(row_q - 1'b1)];
    dn_row = active[REGBITS'(row_q + 1'b1)];
    if (WRAP == 0) begin
      if (row_q == '0) up_row = '0;
      if (row_q == LAST_ROW) dn_row = '0;
    end
    next_row = life_row(up_row, active[row_q], dn_row);
  end

  // State register.
  always_ff @(posedge ph2 or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (step) state_d = COMPUTE;
      COMPUTE: if (row_q == LAST_ROW) state_d = SWAP;
      SWAP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control outputs decoded from state.
  always_comb begin
    seed_wr = 1'b0;
    row_wr  = 1'b0;
    swap    = 1'b0;
    case (state_q)
      IDLE:    seed_wr = we;
      COMPUTE: row_wr  = 1'b1;
      SWAP:    swap    = 1'b1;
      default: ;
    endcase
  end

  // Storage: seeds land in the active bank, computed rows in the shadow bank.
  always_ff @(posedge ph2 or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < int'(ROWS); r++) bank_q[b][r] <= '0;
    end else begin
      if (seed_wr) bank_q[sel_q][wa]     <= wd;
      if (row_wr)  bank_q[~sel_q][row_q] <= next_row;
    end
  end

  // Row counter, bank select and status outputs.
  always_ff @(posedge ph2 or posedge reset) begin
    if (reset) begin
      row_q     <= '0;
      sel_q     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      gen_count <= '0;
    end else begin
      row_q <= row_wr ? REGBITS'(row_q + 1'b1) : '0;
      busy  <= (state_d != IDLE);
      done  <= swap;
      if (swap) begin
        sel_q     <= ~sel_q;
        gen_count <= gen_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_cgol_board.sv
// Testbench for cgol_board: drives a dead-border and a toroidal instance with the
// same inputs and compares both against a cell-by-cell Life model.
module tb_cgol_board;

  localparam int ROWS = 8;
  localparam int COLS = 8;

  logic       ph2, reset, we, step;
  logic [2:0] wa, ra;
  logic [7:0] wd;
  logic [7:0] rd0, rd1;
  logic       busy0, busy1, done0, done1, alive0, alive1;
  logic [15:0] gc0, gc1;

  int errors = 0;
  int checks = 0;

  logic [7:0]  mb [2][ROWS];
  logic [15:0] m_gen;

  cgol_board #(.WIDTH(8), .REGBITS(3), .WRAP(0)) dut0 (
    .ph2(ph2), .reset(reset), .we(we), .wa(wa), .wd(wd), .step(step), .ra(ra),
    .rd(rd0), .busy(busy0), .done(done0), .gen_count(gc0), .alive(alive0));

  cgol_board #(.WIDTH(8), .REGBITS(3), .WRAP(1)) dut1 (
    .ph2(ph2), .reset(reset), .we(we), .wa(wa), .wd(wd), .step(step), .ra(ra),
    .rd(rd1), .busy(busy1), .done(done1), .gen_count(gc1), .alive(alive1));

  initial begin
    ph2 = 1'b0;
    forever #5 ph2 = ~ph2;
  end

  // Reference: count the eight neighbours of every cell directly.
  function automatic void model_step(input int w);
    logic [7:0] nb [ROWS];
    int n, rr, cc;
    for (int r = 0; r < ROWS; r++) begin
      nb[r] = '0;
      for (int c = 0; c < COLS; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr == 0 && dc == 0) continue;
            rr = r + dr;
            cc = c + dc;
            if (w == 1) begin
              rr = (rr + ROWS) % ROWS;
              cc = (cc + COLS) % COLS;
            end else if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) continue;
            n += int'(mb[w][rr][cc]);
          end
        nb[r][c] = (n == 3) || (mb[w][r][c] && n == 2);
      end
    end
    for (int r = 0; r < ROWS; r++) mb[w][r] = nb[r];
  endfunction

  function automatic void model_reset();
    for (int w = 0; w < 2; w++)
      for (int r = 0; r < ROWS; r++) mb[w][r] = '0;
    m_gen = '0;
  endfunction

  function automatic bit model_alive(input int w);
    bit a = 0;
    for (int r = 0; r < ROWS; r++) a |= (mb[w][r] != 0);
    return a;
  endfunction

  task automatic apply_reset();
    @(negedge ph2);
    reset = 1'b1;
    @(negedge ph2);
    @(negedge ph2);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic write_row(input logic [2:0] a, input logic [7:0] d);
    @(negedge ph2);
    we = 1'b1; wa = a; wd = d;
    @(negedge ph2);
    we = 1'b0;
    mb[0][a] = d;
    mb[1][a] = d;
  endtask

  // One generation: optional seed write in the step cycle and optional
  // write/step injection while busy. Checks latency, pulses and the new board.
  task automatic run_gen(input string tag, input bit inject, input bit seed_we,
                         input logic [2:0] sa, input logic [7:0] sd);
    int busy_n, done_n, done_at;
    logic [7:0] old0, old1;
    logic [2:0] probe;
    if (seed_we) begin
      mb[0][sa] = sd;
      mb[1][sa] = sd;
    end
    probe = 3'($urandom_range(0, 7));
    if (inject) probe = 3'd5;
    old0 = mb[0][probe];
    old1 = mb[1][probe];
    @(negedge ph2);
    ra = probe;
    step = 1'b1;
    if (seed_we) begin we = 1'b1; wa = sa; wd = sd; end
    @(negedge ph2);
    step = 1'b0;
    we = 1'b0;
    busy_n = 0; done_n = 0; done_at = 0;
    for (int j = 1; j <= ROWS + 6; j++) begin
      if (busy0) busy_n++;
      if (done0) begin done_n++; done_at = j; end
      if (j == 4) begin
        checks++;
        if (rd0 !== old0 || rd1 !== old1 || busy1 !== 1'b1) begin
          errors++;
          $display("FAIL %s read_during_compute row%0d: got %h/%h busy1=%b, want %h/%h busy1=1",
                   tag, probe, rd0, rd1, busy1, old0, old1);
        end
      end
      if (inject && j == 4) begin
        we = 1'b1; wa = 3'd5; wd = 8'hFF; step = 1'b1;
      end else if (inject && j == 6) begin
        we = 1'b0; step = 1'b0;
      end
      @(negedge ph2);
    end
    model_step(0);
    model_step(1);
    m_gen = m_gen + 16'd1;
    checks++;
    if (busy_n != ROWS + 1 || done_n != 1 || done_at != ROWS + 2) begin
      errors++;
      $display("FAIL %s timing: busy_cycles=%0d done_pulses=%0d done_at=%0d, want %0d 1 %0d",
               tag, busy_n, done_n, done_at, ROWS + 1, ROWS + 2);
    end
    checks++;
    if (gc0 !== m_gen || gc1 !== m_gen) begin
      errors++;
      $display("FAIL %s gen_count: got %0d/%0d want %0d", tag, gc0, gc1, m_gen);
    end
    checks++;
    if (alive0 !== model_alive(0) || alive1 !== model_alive(1)) begin
      errors++;
      $display("FAIL %s alive: got %b/%b want %b/%b", tag, alive0, alive1,
               model_alive(0), model_alive(1));
    end
    for (int r = 0; r < ROWS; r++) begin
      ra = 3'(r);
      #1;
      checks++;
      if (rd0 !== mb[0][r] || rd1 !== mb[1][r]) begin
        errors++;
        $display("FAIL %s row%0d: got %b/%b want %b/%b", tag, r, rd0, rd1, mb[0][r], mb[1][r]);
      end
    end
    @(negedge ph2);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (busy0 !== 1'b0 || done0 !== 1'b0 || gc0 !== 16'd0 || alive0 !== 1'b0 ||
        busy1 !== 1'b0 || done1 !== 1'b0 || gc1 !== 16'd0 || alive1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: busy=%b/%b done=%b/%b gc=%0d/%0d alive=%b/%b, want all 0",
               busy0, busy1, done0, done1, gc0, gc1, alive0, alive1);
    end
    for (int r = 0; r < ROWS; r++) begin
      ra = 3'(r);
      #1;
      checks++;
      if (rd0 !== 8'h00 || rd1 !== 8'h00) begin
        errors++;
        $display("FAIL reset_row%0d: got %h/%h want 00", r, rd0, rd1);
      end
    end
  endtask

  task automatic test_blinker(input string tag);
    write_row(3'd3, 8'b00011100);
    run_gen({tag, "_gen1"}, 1'b0, 1'b0, 3'd0, 8'h00);
    for (int r = 0; r < ROWS; r++) begin
      ra = 3'(r);
      #1;
      checks++;
      if (rd0 !== ((r >= 2 && r <= 4) ? 8'b00001000 : 8'b0)) begin
        errors++;
        $display("FAIL %s vertical_row%0d: got %b", tag, r, rd0);
      end
    end
    run_gen({tag, "_gen2"}, 1'b0, 1'b0, 3'd0, 8'h00);
    ra = 3'd3;
    #1;
    checks++;
    if (rd0 !== 8'b00011100 || gc0 !== 16'd2) begin
      errors++;
      $display("FAIL %s back_to_horizontal: row3=%b gc=%0d want 00011100 2", tag, rd0, gc0);
    end
  endtask

  task automatic test_block();
    apply_reset();
    write_row(3'd1, 8'b00011000);
    write_row(3'd2, 8'b00011000);
    for (int i = 0; i < 3; i++) run_gen("block", 1'b0, 1'b0, 3'd0, 8'h00);
    ra = 3'd2;
    #1;
    checks++;
    if (rd0 !== 8'b00011000 || alive0 !== 1'b1 || gc0 !== 16'd3) begin
      errors++;
      $display("FAIL block_still: row2=%b alive=%b gc=%0d want 00011000 1 3", rd0, alive0, gc0);
    end
  endtask

  task automatic test_edges();
    apply_reset();
    write_row(3'd0, 8'b10000011);
    run_gen("edges", 1'b0, 1'b0, 3'd0, 8'h00);
    for (int r = 0; r < ROWS; r++) begin
      ra = 3'(r);
      #1;
      checks++;
      if (rd1 !== ((r == 7 || r <= 1) ? 8'b00000001 : 8'b0) || rd0 !== 8'b0) begin
        errors++;
        $display("FAIL edges_row%0d: torus=%b bounded=%b", r, rd1, rd0);
      end
    end
    checks++;
    if (alive0 !== 1'b0 || alive1 !== 1'b1) begin
      errors++;
      $display("FAIL edges_alive: got %b/%b want 0/1", alive0, alive1);
    end
  endtask

  task automatic test_busy_protect();
    apply_reset();
    write_row(3'd4, 8'b00111000);
    write_row(3'd5, 8'b01110000);
    run_gen("busy_protect", 1'b1, 1'b0, 3'd0, 8'h00);
    repeat (ROWS + 4) begin
      checks++;
      if (busy0 !== 1'b0 || done0 !== 1'b0) begin
        errors++;
        $display("FAIL busy_protect_queued: busy=%b done=%b want 0 0", busy0, done0);
      end
      @(negedge ph2);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    write_row(3'd3, 8'b00011100);
    write_row(3'd6, 8'b11000011);
    @(negedge ph2);
    step = 1'b1;
    @(negedge ph2);
    step = 1'b0;
    repeat (3) @(negedge ph2);
    #2 reset = 1'b1;
    #1;
    model_reset();
    checks++;
    if (busy0 !== 1'b0 || done0 !== 1'b0 || gc0 !== 16'd0 || alive0 !== 1'b0 || alive1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_status: busy=%b done=%b gc=%0d alive=%b/%b", busy0, done0, gc0,
               alive0, alive1);
    end
    for (int r = 0; r < ROWS; r++) begin
      ra = 3'(r);
      #1;
      checks++;
      if (rd0 !== 8'h00 || rd1 !== 8'h00) begin
        errors++;
        $display("FAIL reset_mid_row%0d: got %h/%h want 00", r, rd0, rd1);
      end
    end
    @(negedge ph2);
    reset = 1'b0;
    test_blinker("after_mid_reset");
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      apply_reset();
      for (int r = 0; r < ROWS; r++) write_row(3'(r), 8'($urandom));
      for (int g = 0; g < 3; g++) run_gen("random", 1'b0, 1'b0, 3'd0, 8'h00);
      run_gen("write_and_step", 1'b0, 1'b1, 3'($urandom_range(0, 7)), 8'($urandom));
    end
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; step = 1'b0; wa = '0; wd = '0; ra = '0;
    model_reset();
    test_reset();
    test_blinker("blinker");
    test_block();
    test_edges();
    test_busy_protect();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
